fpu_wb_queue: RTL and testbench

Writeback collector directly downstream of the FP adder and FP multiplier.
- Both units emit fire-and-forget results: flag/address/result, no backpressure.
- This block buffers up to two results per cycle in a small in-order FIFO.
- It drains one entry per cycle to the FP register-file write port via valid/ready.
- It exports a stall-request and a per-register pending bitmap so the issue stage can throttle and detect write hazards.

---
 rtl/fpu_pkg.sv | 23 ++
 rtl/fpu_wb_pending_dec.sv | 30 +++
 rtl/fpu_wb_queue.sv | 193 +++++++++++++++++++
 tb/tb_fpu_wb_queue.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared types and constants for the FP writeback path.
//   fpu_word_t       : 32-bit FP result word
//   fpu_reg_t        : 5-bit FP register index
//   wb_entry_t       : one queued writeback {address, data}
//   FPU_NREGS        : number of FP architectural registers
//   FPU_UNIT_LATENCY : pipeline depth of the adder/multiplier feeding the queue
// ---------------------------------------------------------------------------
package fpu_pkg;

    typedef logic [31:0] fpu_word_t;
    typedef logic [4:0]  fpu_reg_t;

    typedef struct packed {
        fpu_reg_t  address;
        fpu_word_t data;
    } wb_entry_t;

    localparam int FPU_NREGS        = 32;
    localparam int FPU_UNIT_LATENCY = 2;

endpackage

// File: rtl/fpu_wb_pending_dec.sv
// ---------------------------------------------------------------------------
// fpu_wb_pending_dec
// Combinational decode of the queue contents into a per-register pending
// bitmap: bit r is set when any valid slot targets register r. Several slots
// may name the same register; the OR simply merges them.
// Ports:
//   entries : all DEPTH queue slots (valid or not)
//   valid   : per-slot occupancy mask
//   pending : OR of one-hot decoded addresses of valid slots
// ---------------------------------------------------------------------------
module fpu_wb_pending_dec
    import fpu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  wb_entry_t             entries [DEPTH],
    input  logic [DEPTH-1:0]      valid,
    output logic [FPU_NREGS-1:0]  pending
);

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                pending[entries[i].address] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_wb_queue.sv
// ---------------------------------------------------------------------------
// fpu_wb_queue
// In-order writeback collector between the FP adder/multiplier and the FP
// register-file write port. Accepts up to two fire-and-forget results per
// cycle (adder first, then multiplier), drains one per cycle via valid/ready.
//
// Ports:
//   clk, rstn                        : clock, asynchronous active-low reset
//   a_flag/a_address/a_result        : adder result
//   m_flag/m_address/m_result        : multiplier result
//   wb_valid/wb_address/wb_data      : registered head entry to register file
//   wb_ready                         : register file accepts this cycle
//   issue_stall                      : registered, free slots <= STALL_MARGIN
//   pending                          : registered per-register hazard bitmap
//   count                            : current occupancy
//   ovf_err (FPU_WB_OVF_EN only)     : sticky "an enqueue was dropped" flag
//
// Build option: define FPU_WB_OVF_EN to add ovf_err and a saturating drop
// counter (drop_cnt_q, visible through the hierarchy only).
//
// The output registers are a copy of the slot at rptr; that slot stays in the
// storage (and in count/pending) until it is accepted.
// ---------------------------------------------------------------------------
module fpu_wb_queue
    import fpu_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int STALL_MARGIN = 2 * FPU_UNIT_LATENCY
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    a_flag,
    input  logic [4:0]              a_address,
    input  logic [31:0]             a_result,
    input  logic                    m_flag,
    input  logic [4:0]              m_address,
    input  logic [31:0]             m_result,
    output logic                    wb_valid,
    output logic [4:0]              wb_address,
    output logic [31:0]             wb_data,
    input  logic                    wb_ready,
    output logic                    issue_stall,
    output logic [31:0]             pending,
    output logic [$clog2(DEPTH):0]  count
`ifdef FPU_WB_OVF_EN
    ,
    output logic                    ovf_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    wb_entry_t      mem [DEPTH];

    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [PW-1:0]  count_q, count_d;
    logic [PW-1:0]  space;
    logic [PW-1:0]  wm_ptr;
    logic [1:0]     n_acc;
    logic           deq;
    logic           a_acc, m_acc;

    wb_entry_t      a_entry, m_entry;
    wb_entry_t      head_d;
    wb_entry_t      slot_nxt [DEPTH];
    logic [DEPTH-1:0] valid_nxt;

    logic           wb_valid_q, wb_valid_d;
    wb_entry_t      wb_entry_q, wb_entry_d;
    logic           issue_stall_q, issue_stall_d;
    logic [31:0]    pending_q, pending_d;

    assign a_entry = '{address: a_address, data: a_result};
    assign m_entry = '{address: m_address, data: m_result};

    // Pointer / admission logic. A slot being dequeued this cycle counts as
    // free, so an enqueue only drops when the post-update occupancy would
    // exceed DEPTH. Drops hit the multiplier entry first.
    always_comb begin
        deq     = wb_valid_q && wb_ready;
        space   = PW'(DEPTH) - count_q + PW'(deq);
        a_acc   = a_flag && (space != '0);
        m_acc   = m_flag && (space >= (a_acc ? PW'(2) : PW'(1)));
        n_acc   = {1'b0, a_acc} + {1'b0, m_acc};
        wm_ptr  = wptr_q + PW'(a_acc);
        wptr_d  = wptr_q + PW'(n_acc);
        rptr_d  = rptr_q + PW'(deq);
        count_d = count_q + PW'(n_acc) - PW'(deq);
    end

    // Next-cycle view of every slot: storage contents with this cycle's
    // writes folded in, plus occupancy relative to the next read pointer.
    // Both the head register and the pending bitmap load from this view so
    // they describe the queue as it will be after the edge.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [AW-1:0] offset;
            always_comb begin
                slot_nxt[gi] = mem[gi];
                if (a_acc && (wptr_q[AW-1:0] == AW'(gi))) begin
                    slot_nxt[gi] = a_entry;
                end
                if (m_acc && (wm_ptr[AW-1:0] == AW'(gi))) begin
                    slot_nxt[gi] = m_entry;
                end
                offset        = AW'(gi) - rptr_d[AW-1:0];
                valid_nxt[gi] = ({1'b0, offset} < count_d);
            end
        end
    endgenerate

    fpu_wb_pending_dec #(
        .DEPTH   (DEPTH)
    ) u_pending_dec (
        .entries (slot_nxt),
        .valid   (valid_nxt),
        .pending (pending_d)
    );

    always_comb begin
        head_d        = slot_nxt[rptr_d[AW-1:0]];
        wb_valid_d    = (count_d != '0);
        wb_entry_d    = wb_valid_d ? head_d : wb_entry_q;
        issue_stall_d = ((PW'(DEPTH) - count_d) <= PW'(STALL_MARGIN));
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (a_acc) begin
            mem[wptr_q[AW-1:0]] <= a_entry;
        end
        if (m_acc) begin
            mem[wm_ptr[AW-1:0]] <= m_entry;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            wb_valid_q    <= 1'b0;
            wb_entry_q    <= '0;
            issue_stall_q <= 1'b0;
            pending_q     <= '0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            wb_valid_q    <= wb_valid_d;
            wb_entry_q    <= wb_entry_d;
            issue_stall_q <= issue_stall_d;
            pending_q     <= pending_d;
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_address  = wb_entry_q.address;
    assign wb_data     = wb_entry_q.data;
    assign issue_stall = issue_stall_q;
    assign pending     = pending_q;
    assign count       = count_q;

`ifdef FPU_WB_OVF_EN
    logic       drop;
    logic       ovf_err_q, ovf_err_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop       = (a_flag && !a_acc) || (m_flag && !m_acc);
        ovf_err_d  = ovf_err_q || drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_err_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ovf_err_q  <= ovf_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign ovf_err = ovf_err_q;
`endif

endmodule

// File: tb/tb_fpu_wb_queue.sv
// ---------------------------------------------------------------------------
// tb_fpu_wb_queue
// Self-checking bench for fpu_wb_queue. A queue-based reference model tracks
// the expected contents; every cycle the DUT outputs are compared with it.
// ---------------------------------------------------------------------------
module tb_fpu_wb_queue;
    import fpu_pkg::*;

    localparam int DEPTH = 8;
    localparam int SM    = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        a_flag, m_flag;
    logic [4:0]  a_address, m_address;
    logic [31:0] a_result, m_result;
    logic        wb_valid, wb_ready, issue_stall;
    logic [4:0]  wb_address;
    logic [31:0] wb_data, pending;
    logic [3:0]  count;
`ifdef FPU_WB_OVF_EN
    logic        ovf_err;
`endif

    fpu_wb_queue #(.DEPTH(DEPTH), .STALL_MARGIN(SM)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .a_flag      (a_flag),
        .a_address   (a_address),
        .a_result    (a_result),
        .m_flag      (m_flag),
        .m_address   (m_address),
        .m_result    (m_result),
        .wb_valid    (wb_valid),
        .wb_address  (wb_address),
        .wb_data     (wb_data),
        .wb_ready    (wb_ready),
        .issue_stall (issue_stall),
        .pending     (pending),
        .count       (count)
`ifdef FPU_WB_OVF_EN
        ,
        .ovf_err     (ovf_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_drops  = 0;
    wb_entry_t model_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p = '0;
        foreach (model_q[i]) p[model_q[i].address] = 1'b1;
        return p;
    endfunction

    function automatic logic model_stall();
        return (DEPTH - model_q.size()) <= SM;
    endfunction

    task automatic compare_all(input string ph);
        check({ph, ".valid"},   64'(wb_valid),    64'(model_q.size() != 0));
        check({ph, ".count"},   64'(count),       64'(model_q.size()));
        check({ph, ".pending"}, 64'(pending),     64'(model_pending()));
        check({ph, ".stall"},   64'(issue_stall), 64'(model_stall()));
        if (model_q.size() != 0) begin
            check({ph, ".addr"}, 64'(wb_address), 64'(model_q[0].address));
            check({ph, ".data"}, 64'(wb_data),    64'(model_q[0].data));
        end
        $display("[%0t] %s v=%0b a=%0d d=%08h cnt=%0d stall=%0b pend=%08h",
                 $time, ph, wb_valid, wb_address, wb_data, count, issue_stall, pending);
    endtask

    // One clock: drive at negedge, update the model at posedge, check #1 later.
    task automatic cycle(input string ph,
                         input logic af, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mf, input logic [4:0] ma, input logic [31:0] md,
                         input logic rdy);
        @(negedge clk);
        a_flag = af; a_address = aa; a_result = ad;
        m_flag = mf; m_address = ma; m_result = md;
        wb_ready = rdy;
        @(posedge clk);
        if (model_q.size() != 0 && rdy) void'(model_q.pop_front());
        if (af) begin
            if (model_q.size() < DEPTH) model_q.push_back('{address: aa, data: ad});
            else n_drops++;
        end
        if (mf) begin
            if (model_q.size() < DEPTH) model_q.push_back('{address: ma, data: md});
            else n_drops++;
        end
        #1;
        compare_all(ph);
    endtask

    task automatic idle(input string ph, input logic rdy);
        cycle(ph, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rdy);
    endtask

    initial begin
        rstn = 1'b0;
        a_flag = 0; a_address = 0; a_result = 0;
        m_flag = 0; m_address = 0; m_result = 0;
        wb_ready = 0;
        #12;
        check("rst.valid",   64'(wb_valid),    64'd0);
        check("rst.addr",    64'(wb_address),  64'd0);
        check("rst.data",    64'(wb_data),     64'd0);
        check("rst.count",   64'(count),       64'd0);
        check("rst.pending", 64'(pending),     64'd0);
        check("rst.stall",   64'(issue_stall), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Single result: visible one cycle later, gone after acceptance.
        cycle("t1", 1, 5'd3, 32'h40400000, 0, 5'd0, 32'd0, 1);
        check("t1.pend3", 64'(pending[3]), 64'd1);
        idle("t1", 1);
        idle("t1", 1);

        // Same-cycle pair to the same register: adder value lands first.
        cycle("t2", 1, 5'd5, 32'h3F800000, 1, 5'd5, 32'h40000000, 1);
        check("t2.first", 64'(wb_data), 64'h3F800000);
        idle("t2", 1);
        check("t2.second", 64'(wb_data), 64'h40000000);
        idle("t2", 1);

        // Backpressure: occupancy 4 asserts stall, head holds, then drains.
        cycle("t3", 1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222, 0);
        cycle("t3", 1, 5'd3, 32'h33333333, 1, 5'd4, 32'h44444444, 0);
        check("t3.stall4", 64'(issue_stall), 64'd1);
        idle("t3", 0);
        check("t3.hold", 64'(wb_data), 64'h11111111);
        for (int i = 0; i < 5; i++) idle("t3", 1);

        // Full queue: extra pair is dropped, occupancy stays at DEPTH.
        for (int i = 0; i < 4; i++)
            cycle("t4", 1, 5'(2*i), 32'(i), 1, 5'(2*i+1), 32'(i+100), 0);
        cycle("t4", 1, 5'd30, 32'hDEAD0000, 1, 5'd31, 32'hDEAD0001, 0);
        check("t4.full", 64'(count), 64'd8);
`ifdef FPU_WB_OVF_EN
        check("t4.ovf", 64'(ovf_err), 64'd1);
        idle("t4", 0);
        check("t4.ovf_sticky", 64'(ovf_err), 64'd1);
`endif
        for (int i = 0; i < 10; i++) idle("t4", 1);

        // Streaming across pointer wrap, zero data and register 0 included.
        for (int i = 0; i < 20; i++)
            cycle("t5", 1, 5'(i % 3), (i == 4) ? 32'd0 : 32'(32'hA000 + i), 0, 5'd0, 32'd0, 1);
        idle("t5", 1);

        // Asynchronous reset mid-burst.
        for (int i = 0; i < 5; i++) cycle("t6", 1, 5'(i + 8), 32'(i), 0, 5'd0, 32'd0, 0);
        check("t6.pre", 64'(count), 64'd5);
        @(negedge clk);
        a_flag = 0; m_flag = 0;
        #2 rstn = 1'b0;
        #1;
        check("t6.valid", 64'(wb_valid), 64'd0);
        check("t6.count", 64'(count),    64'd0);
        check("t6.pend",  64'(pending),  64'd0);
        model_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) idle("t6", 1);

        // Randomized traffic, throttled on the model's stall like a real issuer.
        for (int i = 0; i < 400; i++) begin
            logic st, af, mf;
            st = model_stall();
            af = !st && ($urandom_range(0, 99) < 60);
            mf = !st && ($urandom_range(0, 99) < 50);
            cycle("rnd", af, 5'($urandom), $urandom, mf, 5'($urandom), $urandom,
                  1'($urandom_range(0, 99) < 65));
        end
        for (int i = 0; i < 12; i++) idle("drain", 1);
        check("end.drops", 64'(n_drops), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
